alu_mdu_seq: RTL

//  Parametrised execute-stage ALU with an iterative multiply/divide unit, a valid/ready handshake and an internal flag register.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_md_unit.sv | 70 +++++++
 rtl/alu_mdu_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared codes and types for the execute-stage ALU/MDU.
// Op groups, per-group func codes, FSM states and the flag bundle.
package alu_pkg;

  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_LOGIC = 2'b01;
  localparam logic [1:0] OP_MD    = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [2:0] F_ADC = 3'd0;
  localparam logic [2:0] F_ADD = 3'd1;
  localparam logic [2:0] F_INC = 3'd2;
  localparam logic [2:0] F_NOT = 3'd3;
  localparam logic [2:0] F_SBB = 3'd4;
  localparam logic [2:0] F_SUB = 3'd5;
  localparam logic [2:0] F_DEC = 3'd6;
  localparam logic [2:0] F_SLT = 3'd7;

  localparam logic [2:0] F_AND = 3'd0;
  localparam logic [2:0] F_OR  = 3'd1;
  localparam logic [2:0] F_RCL = 3'd2;
  localparam logic [2:0] F_RCR = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_SHL = 3'd5;
  localparam logic [2:0] F_SHR = 3'd6;
  localparam logic [2:0] F_SAR = 3'd7;

  localparam logic [2:0] F_MUL  = 3'd0;
  localparam logic [2:0] F_MULH = 3'd1;
  localparam logic [2:0] F_DIVU = 3'd2;
  localparam logic [2:0] F_REMU = 3'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic z;
    logic cy;
    logic ov;
  } flags_t;

endpackage

// File: rtl/alu_md_unit.sv
// Iterative unsigned multiply/divide, one bit per clock.
// Shift-add multiplier and restoring divider share one 2*WIDTH register.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] nxt;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     trial;
  logic [CW-1:0]      cnt;
  logic               div;
  logic               busy;

  assign msum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + {1'b0, dvs & {WIDTH{acc[0]}}};
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};

  always_comb begin
    nxt = {msum, acc[WIDTH-1:1]};
    if (div) begin
      if (trial[WIDTH])
        nxt = {acc[2*WIDTH-2:0], 1'b0};
      else
        nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // The final step is taken combinationally so the top can latch it
  // on the same edge that retires the operation.
  assign done = busy & (cnt == CW'(WIDTH - 1));
  assign hi   = nxt[2*WIDTH-1:WIDTH];
  assign lo   = nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      div  <= 1'b0;
      busy <= 1'b0;
    end else if (start) begin
      acc  <= {{WIDTH{1'b0}}, a};
      dvs  <= b;
      cnt  <= '0;
      div  <= is_div;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with internal flags and an iterative MDU.
// Single-cycle ops retire on the accept edge; MDU ops after WIDTH more.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit MD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             cy,
  output logic             ov,
  output logic             err
);

  localparam int M  = WIDTH - 1;
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  flags_t           fl;
  flags_t           r_fl;
  flags_t           md_fl;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] md_y;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   shl_t;
  logic [WIDTH:0]   shr_t;
  logic [WIDTH:0]   sar_t;
  logic [SW-1:0]    n;
  logic [1:0]       md_func;
  logic             md_dz;
  logic             md_done;
  logic             md_go;
  logic             md_err;
  logic             r_err;
  logic             cin;
  logic             add_ov;
  logic             sub_ov;
  logic             take;

  assign in_ready   = ~rst & (state == IDLE);
  assign take       = in_valid & in_ready;
  assign {z, cy, ov} = fl;

  // INC/DEC reuse the add/sub path with a constant one; ADC/SBB add cy.
  assign opnd   = (func[1:0] == 2'b10) ? ONE : b;
  assign cin    = (func[1:0] == 2'b00) & fl.cy;
  assign add_s  = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
  assign sub_s  = {1'b0, a} - {1'b0, opnd} - {{WIDTH{1'b0}}, cin};
  assign add_ov = (a[M] == opnd[M]) & (add_s[M] != a[M]);
  assign sub_ov = (a[M] != opnd[M]) & (sub_s[M] != a[M]);

  // One guard bit catches the last bit shifted out.
  assign n     = b[SW-1:0];
  assign shl_t = {1'b0, a} << n;
  assign shr_t = {a, 1'b0} >> n;
  assign sar_t = $signed({a, 1'b0}) >>> n;

  always_comb begin
    r_y   = y;
    r_fl  = fl;
    r_err = 1'b0;
    md_go = 1'b0;
    unique case (op)
      OP_ARITH: begin
        unique case (func)
          F_ADC, F_ADD, F_INC: begin
            r_y     = add_s[M:0];
            r_fl.cy = add_s[WIDTH];
            r_fl.ov = add_ov;
          end
          F_NOT: begin
            r_y     = ~b;
            r_fl.cy = 1'b0;
            r_fl.ov = 1'b0;
          end
          default: begin
            r_y     = sub_s[M:0];
            r_fl.cy = sub_s[WIDTH];
            r_fl.ov = sub_ov;
          end
        endcase
        r_fl.z = (func == F_SLT) ? sub_s[WIDTH] : ~|r_y;
      end
      OP_LOGIC: begin
        unique case (func)
          F_AND: begin r_y = a & b; r_fl.cy = 1'b0; end
          F_OR:  begin r_y = a | b; r_fl.cy = 1'b0; end
          F_XOR: begin r_y = a ^ b; r_fl.cy = 1'b0; end
          F_RCL: begin
            r_y     = {a[M-1:0], fl.cy};
            r_fl.cy = a[M];
          end
          F_RCR: begin
            r_y     = {fl.cy, a[M:1]};
            r_fl.cy = a[0];
          end
          F_SHL: begin
            r_y = shl_t[M:0];
            if (n != '0) r_fl.cy = shl_t[WIDTH];
          end
          F_SHR: begin
            r_y = shr_t[WIDTH:1];
            if (n != '0) r_fl.cy = shr_t[0];
          end
          default: begin
            r_y = sar_t[WIDTH:1];
            if (n != '0) r_fl.cy = sar_t[0];
          end
        endcase
        if (func[2:1] != 2'b01) begin
          r_fl.z  = ~|r_y;
          r_fl.ov = 1'b0;
        end
      end
      OP_MD: begin
        if (MD_EN && !func[2]) md_go = 1'b1;
        else                   r_err = 1'b1;
      end
      default: r_err = 1'b1;
    endcase
  end

  always_comb begin
    md_y     = md_func[0] ? md_hi : md_lo;
    md_fl.z  = ~|md_y;
    md_fl.cy = 1'b0;
    md_fl.ov = 1'b0;
    if (md_func == 2'b00) begin
      md_fl.cy = |md_hi;
      md_fl.ov = |md_hi;
    end
    if (md_func[1] & md_dz) begin
      md_fl.cy = 1'b1;
      md_fl.ov = 1'b1;
    end
    md_err = md_func[1] & md_dz;
  end

  if (MD_EN) begin : g_md
    alu_md_unit #(.WIDTH(WIDTH)) u_md (
      .clk    (clk),
      .rst    (rst),
      .start  (take & md_go),
      .is_div (func[1]),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
    );
  end else begin : g_nomd
    assign md_done = 1'b0;
    assign md_hi   = '0;
    assign md_lo   = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      y         <= '0;
      fl        <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      md_func   <= '0;
      md_dz     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            if (md_go) begin
              state   <= RUN;
              md_func <= func[1:0];
              md_dz   <= ~|b;
            end else begin
              y         <= r_y;
              fl        <= r_fl;
              err       <= r_err;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (md_done) begin
            y         <= md_y;
            fl        <= md_fl;
            err       <= md_err;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
